pulse_spacer: RTL and testbench

// - Fast-domain stage feeding the toggle-based fast->slow pulse synchronizer.
// - The synchronizer loses events when input pulses arrive closer together than the slow clock can resolve.
// - This block accepts bursty single-cycle event pulses and queues them as a count.
// - It re-emits them as single-cycle pulses spaced at least MIN_GAP clk cycles apart, and flags events dropped on overflow.

---
 rtl/pulse_pkg.sv | 17 +
 rtl/pulse_gap_timer.sv | 66 ++++++
 rtl/pulse_spacer.sv | 84 ++++++++
 tb/tb_pulse_spacer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse spacer: gap-timer state encodings and
// the gap counter width helper.
package pulse_pkg;

  // IDLE: gap counter is zero and a new pulse may be emitted.
  // HOLD: gap counter is non-zero and emission is blocked.
  typedef enum logic {
    PS_IDLE = 1'b0,
    PS_HOLD = 1'b1
  } ps_state_e;

  // Gap counter width: $clog2(min_gap), never below one bit.
  function automatic int unsigned gap_w(input int unsigned min_gap);
    return (min_gap <= 2) ? 1 : $clog2(min_gap);
  endfunction

endpackage

// File: rtl/pulse_gap_timer.sv
// Gap timer for the pulse spacer. It is loaded with MIN_GAP-1 on every
// emitted pulse and counts down to zero. No new pulse may be emitted until
// the count reaches zero.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   load       an emit happened this cycle (only honoured in IDLE)
//   done_c     timer idle this cycle, so an emit is allowed
//   running_c  gap count will be non-zero next cycle
module pulse_gap_timer
  import pulse_pkg::*;
#(
  parameter int unsigned MIN_GAP = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done_c,
  output logic running_c
);

  localparam int unsigned GW = gap_w(MIN_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  ps_state_e       state;
  logic [GW-1:0]   gap_cnt;

  // State and gap counter; HOLD always carries a non-zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PS_IDLE;
      gap_cnt <= '0;
    end else begin
      case (state)
        PS_IDLE: begin
          if (load) begin
            gap_cnt <= GAP_LOAD;
            state   <= (MIN_GAP > 1) ? PS_HOLD : PS_IDLE;
          end else begin
            gap_cnt <= '0;
          end
        end
        PS_HOLD: begin
          if (gap_cnt > GAP_ONE) begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end else begin
            gap_cnt <= '0;
            state   <= PS_IDLE;
          end
        end
        default: begin
          gap_cnt <= '0;
          state   <= PS_IDLE;
        end
      endcase
    end
  end

  assign done_c = (state == PS_IDLE);

  // Predicts whether gap_cnt will be non-zero after this edge.
  assign running_c = (state == PS_IDLE) ? (load && (MIN_GAP > 1))
                                        : (gap_cnt > GAP_ONE);

endmodule

// File: rtl/pulse_spacer.sv
// Pulse spacer: it queues bursty single-cycle events as a count and
// re-emits them as single-cycle pulses at least MIN_GAP cycles apart. The
// pulses feed a toggle-based fast-to-slow pulse synchronizer. Events that
// arrive while the queue is full are dropped, and a sticky flag records it.
// Ports:
//   clk        fast clock
//   rst        synchronous active-high reset
//   data_in    event request, one event per high cycle
//   clr_ovf    clears the sticky overflow flag (a drop in the same cycle wins)
//   pulse_out  spaced event pulse, registered
//   pending    events accepted but not yet emitted, registered
//   busy       pending or gap timer active, registered
//   overflow   sticky dropped-event flag, registered
module pulse_spacer
  import pulse_pkg::*;
#(
  parameter int unsigned MIN_GAP = 6,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  generate
    if (MIN_GAP < 1 || CNT_W < 1) begin : g_param_check
      $fatal(1, "pulse_spacer: MIN_GAP and CNT_W must both be >= 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             done_c;
  logic             running_c;
  logic             emit_c;
  logic             full_c;
  logic             acc_c;
  logic             drop_c;
  logic [CNT_W-1:0] pending_next_c;

  pulse_gap_timer #(
    .MIN_GAP (MIN_GAP)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (emit_c),
    .done_c    (done_c),
    .running_c (running_c)
  );

  // Emit when the gap has elapsed and there is either a queued or a live event.
  // A live event with an empty queue bypasses the counter.
  assign emit_c = done_c && ((pending != '0) || data_in);
  assign full_c = (pending == CNT_MAX);
  // A full queue still accepts an event in a cycle that also emits one.
  assign acc_c  = data_in && !(full_c && !emit_c);
  assign drop_c = data_in && full_c && !emit_c;
  assign pending_next_c = pending + CNT_W'(acc_c) - CNT_W'(emit_c);

  // Output and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_out <= 1'b0;
      pending   <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      pulse_out <= emit_c;
      pending   <= pending_next_c;
      busy      <= (pending_next_c != '0) || running_c;
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_spacer.sv
// Directed bench for pulse_spacer. It exercises a default instance
// (MIN_GAP=6, CNT_W=4) and a MIN_GAP=1 instance. It also drives a
// behavioural toggle synchronizer into a 3x slower clock domain.
// Cycle n is the interval that begins at posedge n. Inputs set in cycle n
// appear on the registered outputs in cycle n+1.
module tb_pulse_spacer;

  logic clk = 1'b0;
  logic clk_slow = 1'b0;
  always #5  clk = ~clk;
  always #15 clk_slow = ~clk_slow;

  logic       rst0, di0, clr0, po0, busy0, ovf0;
  logic [3:0] pend0;
  logic       rst1, di1, clr1, po1, busy1, ovf1;
  logic [3:0] pend1;

  pulse_spacer #(.MIN_GAP(6), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst0), .data_in(di0), .clr_ovf(clr0),
    .pulse_out(po0), .pending(pend0), .busy(busy0), .overflow(ovf0)
  );

  pulse_spacer #(.MIN_GAP(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst1), .data_in(di1), .clr_ovf(clr1),
    .pulse_out(po1), .pending(pend1), .busy(busy1), .overflow(ovf1)
  );

  // Downstream toggle synchronizer model: a fast toggle, two slow flops and an edge detect.
  logic tg = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   slow_cnt = 0;
  always @(posedge clk) if (po0) tg <= ~tg;
  always @(posedge clk_slow) begin
    s1 <= tg;
    s2 <= s1;
    s3 <= s2;
    if (s2 ^ s3) slow_cnt <= slow_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    di0 = 1'b0; di1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  initial begin
    int n;
    int exp_pend;
    int base;
    int sent;
    int len;

    // Reset values
    do_reset();
    chk("rst_pulse", 32'(po0), 0);
    chk("rst_pending", 32'(pend0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_overflow", 32'(ovf0), 0);

    // Single isolated event in cycle 10
    repeat (10) tick();
    di0 = 1'b1;
    tick();
    di0 = 1'b0;
    chk("single_pulse_c11", 32'(po0), 1);
    chk("single_pending_c11", 32'(pend0), 0);
    chk("single_busy_c11", 32'(busy0), 1);
    for (int c = 12; c <= 16; c++) begin
      tick();
      chk($sformatf("single_pulse_c%0d", c), 32'(po0), 0);
      chk($sformatf("single_busy_c%0d", c), 32'(busy0), (c <= 15) ? 1 : 0);
      chk($sformatf("single_pending_c%0d", c), 32'(pend0), 0);
    end

    // Burst of 4 events in cycles 10..13
    do_reset();
    repeat (10) tick();
    for (int c = 10; c <= 31; c++) begin
      di0 = (c <= 13);
      tick();
      n = c + 1;
      exp_pend = (n <= 11) ? 0 : (n == 12) ? 1 : (n == 13) ? 2 :
                 (n <= 16) ? 3 : (n <= 22) ? 2 : (n <= 28) ? 1 : 0;
      chk($sformatf("burst_pulse_c%0d", n), 32'(po0),
          (n == 11 || n == 17 || n == 23 || n == 29) ? 1 : 0);
      chk($sformatf("burst_pending_c%0d", n), 32'(pend0), 32'(exp_pend));
    end
    chk("burst_overflow", 32'(ovf0), 0);

    // Overflow: data_in high in cycles 0..99
    do_reset();
    di0 = 1'b1;
    for (int c = 0; c <= 99; c++) begin
      tick();
      n = c + 1;
      if (n == 19) begin
        chk("ovf_pending_c19", 32'(pend0), 15);
        chk("ovf_flag_c19", 32'(ovf0), 0);
      end
      if (n == 20) chk("ovf_flag_c20", 32'(ovf0), 1);
    end
    chk("ovf_pending_c100", 32'(pend0), 15);
    chk("ovf_flag_c100", 32'(ovf0), 1);
    di0 = 1'b0;
    tick();
    chk("ovf_sticky_c101", 32'(ovf0), 1);
    chk("ovf_pending_c101", 32'(pend0), 15);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("ovf_cleared_c102", 32'(ovf0), 0);
    tick();
    chk("ovf_pending_c103", 32'(pend0), 14);
    chk("ovf_pulse_c103", 32'(po0), 1);
    di0 = 1'b1;
    tick();
    chk("ovf_pending_c104", 32'(pend0), 15);
    chk("ovf_flag_c104", 32'(ovf0), 0);
    clr0 = 1'b1;
    tick();
    di0 = 1'b0;
    clr0 = 1'b0;
    chk("ovf_set_wins_c105", 32'(ovf0), 1);
    chk("ovf_pending_c105", 32'(pend0), 15);

    // MIN_GAP=1: events in cycles 5..8
    do_reset();
    repeat (5) tick();
    for (int c = 5; c <= 9; c++) begin
      di1 = (c <= 8);
      tick();
      n = c + 1;
      chk($sformatf("g1_pulse_c%0d", n), 32'(po1), (n >= 6 && n <= 9) ? 1 : 0);
      chk($sformatf("g1_pending_c%0d", n), 32'(pend1), 0);
      chk($sformatf("g1_busy_c%0d", n), 32'(busy1), 0);
    end

    // Reset mid-burst with pending=5 and gap_cnt=3 in cycle 9
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      di0 = (c <= 6);
      tick();
    end
    chk("midrst_pending_c9", 32'(pend0), 5);
    chk("midrst_gap_c9", 32'(u_dut0.u_timer.gap_cnt), 3);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("midrst_pulse_c10", 32'(po0), 0);
    chk("midrst_pending_c10", 32'(pend0), 0);
    chk("midrst_busy_c10", 32'(busy0), 0);
    chk("midrst_overflow_c10", 32'(ovf0), 0);
    di0 = 1'b1;
    tick();
    di0 = 1'b0;
    chk("midrst_pulse_c11", 32'(po0), 1);
    chk("midrst_pending_c11", 32'(pend0), 0);

    // Downstream: random bursts through the slow-domain synchronizer
    do_reset();
    repeat (40) tick();
    base = slow_cnt;
    sent = 0;
    for (int b = 0; b < 10; b++) begin
      len = int'($urandom_range(1, 8));
      di0 = 1'b1;
      repeat (len) tick();
      di0 = 1'b0;
      sent += len;
      repeat (70) tick();
    end
    repeat (40) tick();
    chk("sync_event_count", 32'(slow_cnt - base), 32'(sent));
    chk("sync_overflow", 32'(ovf0), 0);
    chk("sync_pending", 32'(pend0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
